// File: rtl/brief_feature_packer.sv
// brief_feature_packer
//   Buffers keypoint records flagged by the BRIEF descriptor stage in a small
//   FIFO and streams each one out as ten 32-bit words on a valid/ready
//   interface. Also keeps per-frame accepted/dropped feature statistics.
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_start, i_end      frame start / end pulses
//   i_flag + record     keypoint record (x, y, depth, score, descriptor)
//   o_word/o_valid/o_last, i_ready   output word stream
//   o_feat_count        features accepted in the last completed frame
//   o_drop_count        features dropped (FIFO full) in the current frame
//   o_overflow          sticky drop indicator since last frame start
//   o_frame_done        one-cycle pulse following i_end
//   o_busy              FIFO non-empty or a record is being sent
module brief_feature_packer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_end,
  input  logic             i_flag,
  input  logic [9:0]       i_coor_x,
  input  logic [9:0]       i_coor_y,
  input  logic [9:0]       i_depth,
  input  logic [7:0]       i_score,
  input  logic [255:0]     i_descriptor,
  output logic [31:0]      o_word,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic [CNT_W-1:0] o_feat_count,
  output logic [CNT_W-1:0] o_drop_count,
  output logic             o_overflow,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int unsigned TAG_W    = 2;
  localparam int unsigned COOR_W   = 10;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned DESC_W   = 256;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned N_WORDS  = 10;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned OCC_W    = ADDR_W + 1;
  localparam int unsigned ENTRY_W  = TAG_W + 3 * COOR_W + SCORE_W + DESC_W;
  localparam int unsigned SREG_W   = WORD_W * N_WORDS;
  localparam int unsigned SCORE_LSB = DESC_W;
  localparam int unsigned DEPTH_LSB = SCORE_LSB + SCORE_W;
  localparam int unsigned Y_LSB     = DEPTH_LSB + COOR_W;
  localparam int unsigned X_LSB     = Y_LSB + COOR_W;
  localparam int unsigned TAG_LSB   = X_LSB + COOR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(N_WORDS - 2);

  typedef enum logic [0:0] {S_IDLE, S_SEND} state_e;

  state_e                state_q, state_d;
  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [SREG_W-1:0]     sreg_q, sreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic [TAG_W-1:0]      frame_id_q, frame_id_d;
  logic [CNT_W-1:0]      feat_q, feat_d, feat_out_q, feat_out_d, drop_q, drop_d;
  logic                  ovf_q, ovf_d, done_q, done_d;

  logic                  full_c, not_empty_c, wr_en_c, drop_c, hs_c, last_hs_c, pop_c;
  logic [ENTRY_W-1:0]    rd_entry_c;
  logic [CNT_W-1:0]      feat_acc_c, drop_acc_c;

  // FIFO status is derived from registered occupancy only, so a write while
  // full is dropped even when a pop happens in the same cycle.
  always_comb begin
    full_c      = (occ_q == OCC_W'(DEPTH));
    not_empty_c = (occ_q != '0);
    wr_en_c     = i_flag && !full_c;
    drop_c      = i_flag && full_c;
    hs_c        = (state_q == S_SEND) && i_ready;
    last_hs_c   = hs_c && (idx_q == LAST_IDX);
    pop_c       = not_empty_c && ((state_q == S_IDLE) || last_hs_c);
    rd_entry_c  = mem_q[rd_ptr_q];
  end

  // Output FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Output FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (not_empty_c) state_d = S_SEND;
      S_SEND:  if (last_hs_c && !not_empty_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stream datapath: load a formatted record on pop, shift one word per handshake
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (pop_c) begin
      sreg_d = {rd_entry_c[TAG_LSB +: TAG_W], rd_entry_c[DEPTH_LSB +: COOR_W],
                rd_entry_c[Y_LSB +: COOR_W], rd_entry_c[X_LSB +: COOR_W],
                24'h0, rd_entry_c[SCORE_LSB +: SCORE_W], rd_entry_c[DESC_W-1:0]};
      idx_d  = '0;
      last_d = 1'b0;
    end else if (hs_c) begin
      sreg_d = {sreg_q[SREG_W-WORD_W-1:0], WORD_W'(0)};
      idx_d  = idx_q + IDX_W'(1);
      last_d = (idx_q == PRE_LAST_IDX);
    end
    valid_d = (state_d == S_SEND);
    busy_d  = (occ_d != '0) || (state_d == S_SEND);
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_en_c ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en_c && !pop_c)      occ_d = occ_q + OCC_W'(1);
    else if (!wr_en_c && pop_c) occ_d = occ_q - OCC_W'(1);
  end

  // Frame statistics: i_end latches (including this cycle's write) before i_start clears
  always_comb begin
    feat_acc_c = (wr_en_c && (feat_q != '1)) ? feat_q + CNT_W'(1) : feat_q;
    drop_acc_c = (drop_c  && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
    feat_out_d = i_end ? feat_acc_c : feat_out_q;
    done_d     = i_end;
    if (i_start) begin
      feat_d     = '0;
      drop_d     = '0;
      ovf_d      = 1'b0;
      frame_id_d = frame_id_q + TAG_W'(1);
    end else begin
      feat_d     = feat_acc_c;
      drop_d     = drop_acc_c;
      ovf_d      = ovf_q | drop_c;
      frame_id_d = frame_id_q;
    end
  end

  // FIFO storage; written with the frame tag current at capture time
  always_ff @(posedge i_clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= {frame_id_q, i_coor_x, i_coor_y, i_depth, i_score, i_descriptor};
  end

  // Datapath and statistics registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      sreg_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      frame_id_q <= '0;
      feat_q     <= '0;
      feat_out_q <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      frame_id_q <= frame_id_d;
      feat_q     <= feat_d;
      feat_out_q <= feat_out_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign o_word       = sreg_q[SREG_W-1 -: WORD_W];
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_feat_count = feat_out_q;
  assign o_drop_count = drop_q;
  assign o_overflow   = ovf_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_brief_feature_packer.sv
// Bench for brief_feature_packer: queue-based reference model checked every
// cycle, plus directed literal checks on the key scenarios.
module tb_brief_feature_packer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0, i_end = 1'b0, i_flag = 1'b0, i_ready = 1'b0;
  logic [9:0]       i_coor_x = '0, i_coor_y = '0, i_depth = '0;
  logic [7:0]       i_score = '0;
  logic [255:0]     i_descriptor = '0;
  logic [31:0]      o_word;
  logic             o_valid, o_last, o_overflow, o_frame_done, o_busy;
  logic [CNT_W-1:0] o_feat_count, o_drop_count;

  brief_feature_packer #(.DEPTH(16), .ADDR_W(4), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_end(i_end),
    .i_flag(i_flag), .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_depth(i_depth),
    .i_score(i_score), .i_descriptor(i_descriptor), .o_word(o_word),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_feat_count(o_feat_count), .o_drop_count(o_drop_count),
    .o_overflow(o_overflow), .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]   tag;
    logic [9:0]   x, y, d;
    logic [7:0]   s;
    logic [255:0] desc;
  } rec_t;

  rec_t       q_m[$];
  rec_t       cur_m;
  rec_t       new_m;
  int         infl_m = 0;     // words of cur_m still to be sent
  logic [1:0] fid_m = '0;
  int         feat_m = 0, drop_m = 0, fcnt_m = 0;
  bit         ovf_m = 0, done_m = 0;
  bit         hs_m, pop_m, acc_m, drp_m;

  function automatic logic [31:0] word_of(input rec_t r, input int k);
    if (k == 0) return {r.tag, r.d, r.y, r.x};
    if (k == 1) return {24'h0, r.s};
    return r.desc[32*(9-k) +: 32];
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_m.delete();
      infl_m = 0; fid_m = '0; feat_m = 0; drop_m = 0; fcnt_m = 0;
      ovf_m = 0; done_m = 0;
    end else begin
      hs_m  = (infl_m > 0) && i_ready;
      pop_m = (q_m.size() > 0) && ((infl_m == 0) || (hs_m && infl_m == 1));
      acc_m = i_flag && (q_m.size() < DEPTH);
      drp_m = i_flag && !acc_m;
      if (pop_m) begin
        cur_m  = q_m.pop_front();
        infl_m = 10;
      end else if (hs_m) begin
        infl_m--;
      end
      if (acc_m) begin
        new_m.tag = fid_m; new_m.x = i_coor_x; new_m.y = i_coor_y;
        new_m.d = i_depth; new_m.s = i_score; new_m.desc = i_descriptor;
        q_m.push_back(new_m);
      end
      done_m = i_end;
      if (i_end) fcnt_m = sat(feat_m + int'(acc_m));
      if (i_start) begin
        feat_m = 0; drop_m = 0; ovf_m = 0; fid_m = fid_m + 2'd1;
      end else begin
        feat_m = sat(feat_m + int'(acc_m));
        drop_m = sat(drop_m + int'(drp_m));
        ovf_m  = ovf_m | drp_m;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge i_clk) begin
    chk("valid", o_valid, infl_m > 0);
    if (infl_m > 0) begin
      chk("word", o_word, word_of(cur_m, 10 - infl_m));
      chk("last", o_last, infl_m == 1);
    end
    chk("feat_count", o_feat_count, fcnt_m);
    chk("drop_count", o_drop_count, drop_m);
    chk("overflow", o_overflow, ovf_m);
    chk("frame_done", o_frame_done, done_m);
    chk("busy", o_busy, (q_m.size() > 0) || (infl_m > 0));
    if (o_valid && i_ready) hs_count++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rand_rec();
    i_coor_x = 10'($urandom); i_coor_y = 10'($urandom);
    i_depth  = 10'($urandom); i_score  = 8'($urandom);
    for (int k = 0; k < 8; k++) i_descriptor[32*k +: 32] = $urandom;
  endtask

  task automatic drain();
    int n;
    i_flag = 0; i_start = 0; i_end = 0; i_ready = 1;
    n = 0;
    while (o_busy && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_done", o_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int hs_base;

  initial begin
    // Reset state
    @(negedge i_clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_word", o_word, 32'h0);
    chk("rst_busy", o_busy, 1'b0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    tick();

    // 1: single record, ready high; w0 two cycles after the flag
    i_ready = 1;
    i_coor_x = 10'd5; i_coor_y = 10'd7; i_depth = 10'd300; i_score = 8'h2A;
    for (int b = 0; b < 32; b++) i_descriptor[8*b +: 8] = 8'(b);
    i_flag = 1;
    tick();
    i_flag = 0;
    tick();
    @(negedge i_clk);
    chk("t1_w0_valid", o_valid, 1'b1);
    chk("t1_w0", o_word, 32'h12C01C05);
    chk("t1_w0_last", o_last, 1'b0);
    tick(); @(negedge i_clk);
    chk("t1_w1", o_word, 32'h0000002A);
    tick(); @(negedge i_clk);
    chk("t1_w2", o_word, 32'h1F1E1D1C);
    for (int w = 3; w <= 9; w++) tick();
    @(negedge i_clk);
    chk("t1_w9", o_word, 32'h03020100);
    chk("t1_w9_last", o_last, 1'b1);
    drain();

    // 2: fill while stalled; first record is already in the shift register,
    // so 17 are held and the 18th is dropped
    i_ready = 0;
    for (int i = 0; i < 18; i++) begin
      rand_rec();
      i_flag = 1;
      tick();
    end
    i_flag = 0;
    @(negedge i_clk);
    chk("t2_drop", o_drop_count, 16'd1);
    chk("t2_ovf", o_overflow, 1'b1);
    hs_base = hs_count;
    drain();
    chk("t2_words", 64'(hs_count - hs_base), 64'd170);

    // 4: start, three features, end with a fourth in the same cycle
    i_start = 1;
    tick();
    i_start = 0; rand_rec(); i_flag = 1;
    tick();
    rand_rec();
    tick();
    rand_rec();
    @(negedge i_clk);
    chk("t4_first_valid", o_valid, 1'b1);
    chk("t4_first_tag", 64'(o_word[31:30]), 64'd1);
    tick();
    rand_rec(); i_end = 1;
    tick();
    i_flag = 0; i_end = 0;
    @(negedge i_clk);
    chk("t4_feat", o_feat_count, 16'd4);
    chk("t4_done", o_frame_done, 1'b1);
    tick();
    @(negedge i_clk);
    chk("t4_done_pulse", o_frame_done, 1'b0);
    drain();

    // 5: new frame (id 2), two features, end+start together (-> id 3)
    i_start = 1;
    tick();
    i_start = 0; rand_rec(); i_flag = 1;
    tick();
    rand_rec();
    tick();
    i_flag = 0; i_end = 1; i_start = 1;
    tick();
    i_end = 0; i_start = 0;
    @(negedge i_clk);
    chk("t5_feat", o_feat_count, 16'd2);
    chk("t5_done", o_frame_done, 1'b1);
    chk("t5_drop_clr", o_drop_count, 16'd0);
    chk("t5_ovf_clr", o_overflow, 1'b0);
    drain();
    rand_rec(); i_flag = 1;
    tick();
    i_flag = 0;
    tick();
    @(negedge i_clk);
    chk("t5_next_valid", o_valid, 1'b1);
    chk("t5_next_tag", 64'(o_word[31:30]), 64'd3);
    drain();

    // 3: random traffic with random backpressure and frame pulses
    for (int c = 0; c < 1200; c++) begin
      i_ready = ($urandom_range(0, 99) < ((c < 600) ? 50 : 85));
      i_flag  = ($urandom_range(0, 9) < 3);
      i_start = ($urandom_range(0, 39) == 0);
      i_end   = ($urandom_range(0, 39) == 0);
      rand_rec();
      tick();
    end
    drain();

    // 6: reset in the middle of a record (word 4)
    rand_rec(); i_flag = 1;
    tick();
    i_flag = 0;
    repeat (5) tick();
    @(negedge i_clk);
    chk("t6_pre_valid", o_valid, 1'b1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 1'b0);
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_word", o_word, 32'h0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    rand_rec(); i_flag = 1;
    tick();
    i_flag = 0;
    tick();
    @(negedge i_clk);
    chk("t6_new_valid", o_valid, 1'b1);
    chk("t6_new_tag", 64'(o_word[31:30]), 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
